// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard: register count,
// select/counter widths and the one-hot decode helper.
package reg_scoreboard_pkg;

  localparam int NUM_REGS    = 8;
  localparam int SEL_W       = 3;
  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 16;

  typedef logic [SEL_W-1:0]       reg_sel_t;
  typedef logic [CNT_W-1:0]       cnt_t;
  typedef logic [NUM_REGS-1:0]    reg_vec_t;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Most in-flight writes a single register can track.
  localparam cnt_t CNT_MAX = '1;

  function automatic reg_vec_t sel_onehot(input reg_sel_t sel, input logic en);
    reg_vec_t onehot;
    onehot      = '0;
    onehot[sel] = en;
    return onehot;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/write-back handshake between the issue stage and the register
// scoreboard; master is the pipeline side, slave is the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic       issue_valid;
  logic       issue_src1_used;
  reg_sel_t   issue_src1_sel;
  logic       issue_src2_used;
  reg_sel_t   issue_src2_sel;
  logic       issue_dst_wen;
  reg_sel_t   issue_dst_sel;
  logic       wb_valid;
  reg_sel_t   wb_sel;
  logic       flush;
  logic       stall;
  reg_vec_t   busy_vec;
  stall_cnt_t stall_cnt;
  logic       err;

  modport master (
    output issue_valid, issue_src1_used, issue_src1_sel,
           issue_src2_used, issue_src2_sel,
           issue_dst_wen, issue_dst_sel,
           wb_valid, wb_sel, flush,
    input  stall, busy_vec, stall_cnt, err
  );

  modport slave (
    input  issue_valid, issue_src1_used, issue_src1_sel,
           issue_src2_used, issue_src2_sel,
           issue_dst_wen, issue_dst_sel,
           wb_valid, wb_sel, flush,
    output stall, busy_vec, stall_cnt, err
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register: counts accepted
// writes up and write-backs down, cleared by flush, flags underflow.
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output cnt_t count,
  output logic nonzero,
  output logic underflow
);

  // NOTE: state uses non-blocking assignments so every counter samples the
  // same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + cnt_t'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - cnt_t'(1);
    end
  end

  assign nonzero   = |count;
  // A retire with nothing pending is a protocol error; flush masks it.
  assign underflow = dec & ~inc & ~clr & ~nonzero;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard tracker: per-register pending-write counters, issue
// stall, stall-cycle counter and sticky error. Optional macro
// SCOREBOARD_WB_BYPASS_EN lets a source issue in its final write-back cycle.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  bus
);

  cnt_t       count [NUM_REGS];
  reg_vec_t   nonzero;
  reg_vec_t   underflow;
  reg_vec_t   inc_vec;
  reg_vec_t   dec_vec;
  reg_vec_t   src_busy;
  logic       hazard;
  logic       stall;
  logic       accept;
  stall_cnt_t stall_cnt;
  logic       err;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    src_busy = nonzero;
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last outstanding write lands this cycle; decode reads the wb bus.
    if (bus.wb_valid && count[bus.wb_sel] == cnt_t'(1)) begin
      src_busy[bus.wb_sel] = 1'b0;
    end
`endif
    hazard = (bus.issue_src1_used & src_busy[bus.issue_src1_sel])
           | (bus.issue_src2_used & src_busy[bus.issue_src2_sel])
           | (bus.issue_dst_wen & (count[bus.issue_dst_sel] == CNT_MAX));
    stall  = bus.issue_valid & hazard & ~bus.flush;
    accept = bus.issue_valid & ~stall & ~bus.flush;
  end

  assign inc_vec = sel_onehot(bus.issue_dst_sel, accept & bus.issue_dst_wen);
  assign dec_vec = sel_onehot(bus.wb_sel, bus.wb_valid);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[i]),
      .dec       (dec_vec[i]),
      .clr       (bus.flush),
      .count     (count[i]),
      .nonzero   (nonzero[i]),
      .underflow (underflow[i])
    );
  end

  // NOTE: only control/status flops live here and all take the async reset;
  // there is no storage array that could be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + stall_cnt_t'(1);
      end
      if (|underflow) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.busy_vec  = nonzero;
  assign bus.stall_cnt = stall_cnt;
  assign bus.err       = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed stimulus, a per-register
// pending-count model checked every cycle, plus hand-computed literals.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  reg_scoreboard_if bus ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain integer pending counts, sticky error, stall counter.
  int m_cnt [NUM_REGS];
  bit m_err;
  int m_stall_cnt;

  function automatic bit m_src_busy(input int s);
    bit b;
    b = (m_cnt[s] != 0);
    if (BYPASS && bus.wb_valid && int'(bus.wb_sel) == s && m_cnt[s] == 1) b = 1'b0;
    return b;
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = (bus.issue_src1_used && m_src_busy(int'(bus.issue_src1_sel)))
      || (bus.issue_src2_used && m_src_busy(int'(bus.issue_src2_sel)))
      || (bus.issue_dst_wen && m_cnt[bus.issue_dst_sel] == 3);
    return bus.issue_valid && hz && !bus.flush;
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i] = (m_cnt[i] != 0);
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
      m_err       = 1'b0;
      m_stall_cnt = 0;
    end else begin
      bit st;
      bit acc;
      st  = m_stall();
      acc = bus.issue_valid && !st && !bus.flush;
      if (st && m_stall_cnt < 65535) m_stall_cnt++;
      if (bus.flush) begin
        for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          bit inc;
          bit dec;
          inc = acc && bus.issue_dst_wen && int'(bus.issue_dst_sel) == i;
          dec = bus.wb_valid && int'(bus.wb_sel) == i;
          if (inc && !dec) m_cnt[i]++;
          else if (dec && !inc) begin
            if (m_cnt[i] == 0) m_err = 1'b1;
            else m_cnt[i]--;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("model_stall", 32'(bus.stall), 32'(m_stall()));
      check("model_busy", 32'(bus.busy_vec), 32'(m_busy()));
      check("model_stall_cnt", 32'(bus.stall_cnt), 32'(m_stall_cnt));
      check("model_err", 32'(bus.err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid     = 1'b0;
    bus.issue_src1_used = 1'b0;
    bus.issue_src1_sel  = '0;
    bus.issue_src2_used = 1'b0;
    bus.issue_src2_sel  = '0;
    bus.issue_dst_wen   = 1'b0;
    bus.issue_dst_sel   = '0;
    bus.wb_valid        = 1'b0;
    bus.wb_sel          = '0;
    bus.flush           = 1'b0;
  endtask

  task automatic issue_dst(input int d);
    idle();
    bus.issue_valid   = 1'b1;
    bus.issue_dst_wen = 1'b1;
    bus.issue_dst_sel = reg_sel_t'(d);
  endtask

  task automatic wb(input int d);
    bus.wb_valid = 1'b1;
    bus.wb_sel   = reg_sel_t'(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle();
    // Reset with a would-be hazard presented: nothing is pending, so no stall.
    bus.issue_valid     = 1'b1;
    bus.issue_src1_used = 1'b1;
    bus.issue_src1_sel  = 3'd3;
    #2;
    check("rst_busy", 32'(bus.busy_vec), 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    idle();

    // RAW on r3, then write-back resolves it.
    issue_dst(3);
    tick();
    idle();
    #1;
    check("raw_busy", 32'(bus.busy_vec), 32'h08);
    bus.issue_valid     = 1'b1;
    bus.issue_src1_used = 1'b1;
    bus.issue_src1_sel  = 3'd3;
    #1;
    check("raw_stall", 32'(bus.stall), 32'h1);
    tick();
    check("raw_stall_cnt", 32'(bus.stall_cnt), 32'h1);
    wb(3);
    #1;
    check("wb_cycle_stall", 32'(bus.stall), BYPASS ? 32'h0 : 32'h1);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    check("after_wb_busy", 32'(bus.busy_vec), 32'h0);
    check("after_wb_stall", 32'(bus.stall), 32'h0);
    check("after_wb_stall_cnt", 32'(bus.stall_cnt), BYPASS ? 32'h1 : 32'h2);
    tick();
    idle();

    // WAW up to the counter maximum on r5.
    for (int k = 0; k < 3; k++) begin
      issue_dst(5);
      tick();
    end
    issue_dst(5);
    #1;
    check("max_stall", 32'(bus.stall), 32'h1);
    check("max_busy", 32'(bus.busy_vec), 32'h20);
    tick();
    wb(5);
    #1;
    check("max_wb_stall", 32'(bus.stall), 32'h1);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    check("max_issue", 32'(bus.stall), 32'h0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      wb(5);
      tick();
    end
    idle();
    #1;
    check("max_drained", 32'(bus.busy_vec), 32'h0);

    // Simultaneous accept and write-back on r2 with one pending.
    issue_dst(2);
    tick();
    issue_dst(2);
    wb(2);
    tick();
    idle();
    #1;
    check("incdec_busy", 32'(bus.busy_vec), 32'h04);
    wb(2);
    tick();
    idle();
    #1;
    check("incdec_drain", 32'(bus.busy_vec), 32'h0);

    // Underflow on r6 sets a sticky error.
    wb(6);
    tick();
    idle();
    #1;
    check("uflow_err", 32'(bus.err), 32'h1);
    issue_dst(1);
    tick();
    idle();
    wb(1);
    tick();
    idle();
    #1;
    check("uflow_sticky", 32'(bus.err), 32'h1);

    // Flush with a stalling instruction presented: no accept, all clear.
    issue_dst(1);
    tick();
    issue_dst(4);
    tick();
    issue_dst(7);
    bus.issue_src1_used = 1'b1;
    bus.issue_src1_sel  = 3'd1;
    bus.flush           = 1'b1;
    #1;
    check("flush_stall", 32'(bus.stall), 32'h0);
    check("flush_busy_pre", 32'(bus.busy_vec), 32'h12);
    tick();
    idle();
    #1;
    check("flush_busy", 32'(bus.busy_vec), 32'h0);

    // Reset mid-stall clears everything immediately.
    issue_dst(0);
    tick();
    idle();
    bus.issue_valid     = 1'b1;
    bus.issue_src2_used = 1'b1;
    bus.issue_src2_sel  = 3'd0;
    #1;
    check("pre_rst_stall", 32'(bus.stall), 32'h1);
    tick();
    tick();
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus.stall), 32'h0);
    check("mid_rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    check("mid_rst_busy", 32'(bus.busy_vec), 32'h0);
    check("mid_rst_err", 32'(bus.err), 32'h0);
    tick();
    rst = 1'b1;
    issue_dst(3);
    tick();
    idle();
    #1;
    check("post_rst_busy", 32'(bus.busy_vec), 32'h08);
    check("post_rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
